// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the six-digit dynamic seven-segment display path:
// active-low segment codes (seg[7]=dp, seg[6:0]=g..a), digit count, the
// clamp limit for the binary input and the conversion FSM state type.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int DIG_NUM = 6;      // digits on the board, fixed
  localparam int BIN_W   = 20;     // width of the binary value
  localparam int BCD_W   = 4 * DIG_NUM;

  localparam logic [BIN_W-1:0] BIN_MAX    = 20'd999_999;
  localparam logic [4:0]       SHIFT_LAST = 5'd19;  // 20 shift cycles, 0..19

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  // Active-low glyph for one BCD digit; non-decimal codes render dark.
  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_of_digit = SEG_0;
      4'd1:    seg_of_digit = SEG_1;
      4'd2:    seg_of_digit = SEG_2;
      4'd3:    seg_of_digit = SEG_3;
      4'd4:    seg_of_digit = SEG_4;
      4'd5:    seg_of_digit = SEG_5;
      4'd6:    seg_of_digit = SEG_6;
      4'd7:    seg_of_digit = SEG_7;
      4'd8:    seg_of_digit = SEG_8;
      4'd9:    seg_of_digit = SEG_9;
      default: seg_of_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_dyn_scan_if.sv
// -----------------------------------------------------------------------------
// seg_dyn_scan_if
// Value bus from the data generator to the display:
//   data   [19:0]  unsigned value to show (clamped to 999999 by the display)
//   point  [5:0]   decimal point enables, bit 0 = rightmost digit
//   sign           1 = show a minus sign
//   seg_en         1 = display on, 0 = all digits dark
// master: producer side, slave: display side.
// -----------------------------------------------------------------------------
interface seg_dyn_scan_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  modport master (output data, point, sign, seg_en);
  modport slave  (input  data, point, sign, seg_en);
endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, 20-bit binary to six BCD nibbles.
// FSM: IDLE -> LOAD -> SHIFT (20 cycles) -> DONE -> IDLE, 23 cycles per pass
// when start is held high.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a conversion from IDLE
//   bin_in  [19:0]  value sampled in LOAD (must already be <= 999999)
//   load            high during the LOAD cycle (lets the caller shadow side data)
//   done            high during the DONE cycle; bcd_out is valid then
//   bcd_out [23:0]  result, nibble i = decimal digit i
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             load,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [4:0]       cnt_q, cnt_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  // Add-3 correction: any nibble >= 5 would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bin_d   = bin_in;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == SHIFT_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load    = (state_q == LOAD);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/seg_dyn_scan.sv
// -----------------------------------------------------------------------------
// seg_dyn_scan
// Six-digit common-anode dynamic seven-segment driver. Converts the value on
// the value bus to BCD continuously, latches each finished conversion into
// display registers and scans one digit per CNT_MAX+1 clock cycles.
// Ports:
//   sys_clk, sys_rst_n  clock, synchronous active-low reset
//   val_if              value bus (data/point/sign/seg_en), slave side
//   sel [5:0]           one-hot digit select, active-high, sel[0] = rightmost
//   seg [7:0]           active-low segment code, seg[7]=dp, 8'hFF = blank
// Build option: SEG_ZERO_BLANK_EN enables leading-zero blanking with the minus
// sign placed just left of the most significant shown digit; without it all
// six digits are shown and the minus replaces digit 5 only when it is zero.
// -----------------------------------------------------------------------------
module seg_dyn_scan
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  seg_dyn_scan_if.slave     val_if,
  output logic [5:0]        sel,
  output logic [7:0]        seg
);

  // ---------------- conversion ----------------
  logic [BIN_W-1:0] data_clamped;
  logic             bcd_load;
  logic             bcd_done;
  logic [BCD_W-1:0] bcd_value;

  assign data_clamped = (val_if.data > BIN_MAX) ? BIN_MAX : val_if.data;

  bin2bcd_seq u_bin2bcd (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .start   (1'b1),
    .bin_in  (data_clamped),
    .load    (bcd_load),
    .done    (bcd_done),
    .bcd_out (bcd_value)
  );

  // Shadow point/sign alongside the value so a displayed frame is coherent.
  logic [5:0]       point_sh_q, point_sh_d;
  logic             sign_sh_q,  sign_sh_d;
  logic [BCD_W-1:0] disp_bcd_q,   disp_bcd_d;
  logic [5:0]       disp_point_q, disp_point_d;
  logic             disp_sign_q,  disp_sign_d;
  logic             disp_valid_q, disp_valid_d;

  always_comb begin
    point_sh_d   = point_sh_q;
    sign_sh_d    = sign_sh_q;
    disp_bcd_d   = disp_bcd_q;
    disp_point_d = disp_point_q;
    disp_sign_d  = disp_sign_q;
    disp_valid_d = disp_valid_q;
    if (bcd_load) begin
      point_sh_d = val_if.point;
      sign_sh_d  = val_if.sign;
    end
    if (bcd_done) begin
      disp_bcd_d   = bcd_value;
      disp_point_d = point_sh_q;
      disp_sign_d  = sign_sh_q;
      disp_valid_d = 1'b1;
    end
  end

  // ---------------- digit codes ----------------
  logic [5:0] blank;      // digit is a suppressed leading zero
  logic [5:0] minus_pos;  // digit shows the minus sign
  logic [7:0] dig_code [DIG_NUM];

  always_comb begin : blank_map
`ifdef SEG_ZERO_BLANK_EN
    logic above_zero;  // this digit and all digits to its left are zero
`endif
    blank     = '0;
    minus_pos = '0;
`ifdef SEG_ZERO_BLANK_EN
    above_zero = 1'b1;
    for (int i = DIG_NUM - 1; i >= 1; i--) begin
      above_zero = above_zero & (disp_bcd_q[4*i +: 4] == 4'd0);
      blank[i]   = above_zero;
    end
    // Lowest blanked digit sits just left of the most significant shown one;
    // with no blanked digit the minus has nowhere to go and is dropped.
    if (disp_sign_q) minus_pos = blank & ~{blank[DIG_NUM-2:0], 1'b0};
`else
    if (disp_sign_q && (disp_bcd_q[BCD_W-1 -: 4] == 4'd0)) minus_pos[DIG_NUM-1] = 1'b1;
`endif
  end

  always_comb begin : code_map
    for (int i = 0; i < DIG_NUM; i++) begin
      if (minus_pos[i])  dig_code[i] = SEG_MINUS;
      else if (blank[i]) dig_code[i] = SEG_BLANK;
      else               dig_code[i] = seg_of_digit(disp_bcd_q[4*i +: 4]);
      // dp lights even on blanked or minus digits
      if (disp_point_q[i]) dig_code[i][7] = 1'b0;
    end
  end

  // ---------------- scan ----------------
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic        cnt_wrap;

  always_comb begin : scan_next
    cnt_wrap = (cnt_q == CNT_MAX);
    cnt_d    = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d    = idx_q;
    if (cnt_wrap) idx_d = (idx_q == 3'(DIG_NUM - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  // Outputs are built from the next index so sel and seg flip on the same
  // edge as the index itself.
  always_comb begin : out_next
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (val_if.seg_en && disp_valid_q) begin
      sel_d = 6'b000001 << idx_d;
      seg_d = dig_code[idx_d];
    end
  end

  // NOTE: the display registers are a handful of flops, not a RAM, so they
  // are reset with everything else; a reset mid-conversion leaves them dark.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      point_sh_q   <= '0;
      sign_sh_q    <= 1'b0;
      disp_bcd_q   <= '0;
      disp_point_q <= '0;
      disp_sign_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      seg_q        <= SEG_BLANK;
    end else begin
      point_sh_q   <= point_sh_d;
      sign_sh_q    <= sign_sh_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_point_q <= disp_point_d;
      disp_sign_q  <= disp_sign_d;
      disp_valid_q <= disp_valid_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_dyn_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_dyn_scan
// Self-checking bench for seg_dyn_scan with CNT_MAX = 9 (10 cycles/digit).
// Expected segment codes come from a decimal model of the displayed value.
// -----------------------------------------------------------------------------
module tb_seg_dyn_scan;

  localparam int HOLD   = 10;   // CNT_MAX + 1
  localparam int SETTLE = 50;   // > two conversion passes plus output flop

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sel;
  logic [7:0] seg;

  int vectors     = 0;
  int miscompares = 0;

  seg_dyn_scan_if vif ();

  seg_dyn_scan #(.CNT_MAX(16'd9)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .val_if    (vif),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_code(input int idx, input int value,
                                          input logic [5:0] pt, input logic sgn);
    int v, ndig;
    logic [7:0] code;
    v    = (value > 999999) ? 999999 : value;
    code = glyph((v / pow10(idx)) % 10);
    ndig = 1;
    while (ndig < 6 && v >= pow10(ndig)) ndig++;
`ifdef SEG_ZERO_BLANK_EN
    if (idx >= ndig) code = (sgn && idx == ndig) ? 8'hBF : 8'hFF;
`else
    if (sgn && idx == 5 && ndig < 6) code = 8'hBF;
`endif
    if (pt[idx]) code[7] = 1'b0;
    return code;
  endfunction

  function automatic int sel_index(input logic [5:0] s);
    int r = -1;
    for (int k = 0; k < 6; k++) if (s[k]) r = k;
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic apply(input int value, input logic [5:0] pt, input logic sgn);
    vif.data  = 20'(value);
    vif.point = pt;
    vif.sign  = sgn;
    repeat (SETTLE) @(negedge clk);
  endtask

  // Watch the scan for ncyc cycles: every sample must be a valid digit with the
  // model's code, digits advance 0..5 in order, each held exactly HOLD cycles.
  task automatic observe(input int value, input logic [5:0] pt, input logic sgn,
                         input string tag, input int ncyc);
    int prev_idx = -1;
    int run = 0;
    bit first_run = 1'b1;
    int idx;
    logic [7:0] exp;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idx = sel_index(sel);
      vectors++;
      if (!$onehot(sel)) begin
        miscompares++;
        $display("FAIL %s sel one-hot: got %b expected one bit set", tag, sel);
      end else begin
        exp = exp_code(idx, value, pt, sgn);
        vectors++;
        if (seg !== exp) begin
          miscompares++;
          $display("FAIL %s seg digit%0d: got %h expected %h", tag, idx, seg, exp);
        end
      end
      if (prev_idx >= 0 && idx != prev_idx) begin
        vectors++;
        if (idx != (prev_idx + 1) % 6) begin
          miscompares++;
          $display("FAIL %s scan order: got digit%0d expected digit%0d", tag, idx, (prev_idx + 1) % 6);
        end
        if (!first_run) begin
          vectors++;
          if (run != HOLD) begin
            miscompares++;
            $display("FAIL %s digit hold: got %0d cycles expected %0d", tag, run, HOLD);
          end
        end
        first_run = 1'b0;
        run = 0;
      end
      run++;
      prev_idx = idx;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    rst_n       = 1'b0;
    vif.data    = 20'd123456;
    vif.point   = 6'b000100;
    vif.sign    = 1'b0;
    vif.seg_en  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (sel !== 6'b0 || seg !== 8'hFF) begin
        miscompares++;
        $display("FAIL reset outputs: got sel=%b seg=%h expected sel=000000 seg=ff", sel, seg);
      end
    end
    rst_n = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sel !== 6'b0) begin
        seen = c;
        break;
      end
    end
    vectors++;
    if (seen == 0 || seen > 33) begin
      miscompares++;
      $display("FAIL reset first digit: got %0d cycles (0=never) expected 1..33", seen);
    end
  endtask

  task automatic test_directed();
    int         val_t [6] = '{123456, 42, 1000000, 999999, 0, 42};
    logic [5:0] pt_t  [6] = '{6'b000100, 6'b000000, 6'b000000, 6'b000000, 6'b000001, 6'b100001};
    logic       sg_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      apply(val_t[t], pt_t[t], sg_t[t]);
      observe(val_t[t], pt_t[t], sg_t[t], $sformatf("directed%0d", t), 70);
    end
  endtask

  task automatic test_random();
    int         v;
    logic [5:0] pt;
    logic       sg;
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 99999));
        2:       v = int'($urandom_range(0, 1048575));
        default: v = int'($urandom_range(999990, 1048575));
      endcase
      pt = 6'($urandom);
      sg = 1'($urandom);
      apply(v, pt, sg);
      observe(v, pt, sg, $sformatf("random%0d", t), 62);
    end
  endtask

  task automatic test_seg_en();
    int         v  = 305070;
    logic [5:0] pt = 6'b010010;
    logic       sg = 1'b0;
    logic [5:0] prev;
    int         k, pos, changed, d;
    apply(v, pt, sg);
    prev = sel;
    changed = 0;
    for (int c = 0; c < 3 * HOLD; c++) begin
      @(negedge clk);
      if (sel !== prev) begin
        changed = 1;
        break;
      end
    end
    vectors++;
    if (!changed) begin
      miscompares++;
      $display("FAIL seg_en sync: got no digit change expected one within %0d cycles", 3 * HOLD);
      return;
    end
    k = sel_index(sel);   // this sample is position 0 of digit k
    for (pos = 1; pos <= 45; pos++) begin
      if (pos == 4)  vif.seg_en = 1'b0;   // applied at the next edge
      if (pos == 19) vif.seg_en = 1'b1;
      @(negedge clk);
      vectors++;
      if (pos >= 4 && pos <= 18) begin
        if (sel !== 6'b0 || seg !== 8'hFF) begin
          miscompares++;
          $display("FAIL seg_en off pos%0d: got sel=%b seg=%h expected sel=000000 seg=ff", pos, sel, seg);
        end
      end else begin
        d = (k + pos / HOLD) % 6;
        if (sel !== (6'b000001 << d) || seg !== exp_code(d, v, pt, sg)) begin
          miscompares++;
          $display("FAIL seg_en scan pos%0d: got sel=%b seg=%h expected sel=%b seg=%h",
                   pos, sel, seg, 6'b000001 << d, exp_code(d, v, pt, sg));
        end
      end
    end
  endtask

  task automatic test_reset_midconv();
    apply(777, 6'b000000, 1'b1);
    repeat ($urandom_range(1, 22)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (sel !== 6'b0 || seg !== 8'hFF) begin
      miscompares++;
      $display("FAIL midconv reset: got sel=%b seg=%h expected sel=000000 seg=ff", sel, seg);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (sel !== 6'b0 || seg !== 8'hFF) begin
        miscompares++;
        $display("FAIL midconv dark cycle%0d: got sel=%b seg=%h expected sel=000000 seg=ff", c, sel, seg);
      end
    end
    repeat (SETTLE) @(negedge clk);
    observe(777, 6'b000000, 1'b1, "midconv recover", 62);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_seg_en();
    test_reset_midconv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
